// File: rtl/vga_pixel_pipe.sv
// Two-stage pixel pipeline behind vga_controller: sync generation, tile decode to RGB,
// and a frame-divided game tick issued at the start of vertical blanking.
module vga_pixel_pipe #(
  parameter int unsigned HACTIVE     = 640,
  parameter int unsigned HFP         = 16,
  parameter int unsigned HSYNC       = 96,
  parameter int unsigned HBP         = 48,
  parameter int unsigned VACTIVE     = 480,
  parameter int unsigned VFP         = 10,
  parameter int unsigned VSYNC       = 2,
  parameter int unsigned TILE        = 20,
  parameter int unsigned CBITS       = 2,
  parameter int unsigned TICK_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       row,
  input  logic [9:0]       col,
  input  logic             re,
  input  logic [2:0]       rdata,
  output logic             hsync,
  output logic             vsync,
  output logic [CBITS-1:0] red,
  output logic [CBITS-1:0] green,
  output logic [CBITS-1:0] blue,
  output logic             game_tick
);

  localparam logic [9:0] HActive    = 10'(HACTIVE);
  localparam logic [9:0] HSyncStart = 10'(HACTIVE + HFP);
  localparam logic [9:0] HSyncEnd   = 10'(HACTIVE + HFP + HSYNC);
  localparam logic [9:0] HLast      = 10'(HACTIVE + HFP + HSYNC + HBP - 1);
  localparam logic [9:0] VActive    = 10'(VACTIVE);
  localparam logic [9:0] VSyncStart = 10'(VACTIVE + VFP);
  localparam logic [9:0] VSyncEnd   = 10'(VACTIVE + VFP + VSYNC);
  localparam logic [4:0] TileMax    = 5'(TILE - 1);
  localparam logic [5:0] TickMax    = 6'(TICK_FRAMES - 1);
  localparam logic [CBITS-1:0] CMax = {CBITS{1'b1}};

  // Stage 1 state
  logic       active_q, hs_q, vs_q, re_d;
  logic [4:0] xoff_q, yoff_q;
  logic [2:0] tile_q;

  // Frame divider state
  logic       vblank_q;
  logic [5:0] frame_q;
  logic       vblank_start;

  // Decode
  logic [2:0]       tile_cur;
  logic             gap;
  logic [CBITS-1:0] red_d, green_d, blue_d;

  assign vblank_start = (row == 10'd0) && (col == VActive);

  // The fetched code is forwarded while it is on rdata so a fetch lands with its own pixel.
  assign tile_cur = re_d ? rdata : tile_q;
  assign gap      = (xoff_q == 5'd0) || (yoff_q == 5'd0);

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active_q) begin
      case (tile_cur)
        3'd0: ;
        3'd1: if (!gap) green_d = CMax;
        3'd2: begin
          if (!gap) begin
            if ((xoff_q == 5'd5 || xoff_q == 5'd14) && yoff_q == 5'd6) blue_d = CMax;
            else green_d = CMax;
          end
        end
        3'd3: begin
          if (xoff_q >= 5'd5 && xoff_q <= 5'd14 && yoff_q >= 5'd5 && yoff_q <= 5'd14) begin
            red_d = CMax;
          end
        end
        3'd4: begin
          red_d   = CMax;
          green_d = CMax;
          blue_d  = CMax;
        end
        default: begin
          red_d  = CMax;
          blue_d = CMax;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      re_d      <= 1'b0;
      xoff_q    <= '0;
      yoff_q    <= '0;
      tile_q    <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      vblank_q  <= 1'b0;
      frame_q   <= '0;
      game_tick <= 1'b0;
    end else begin
      active_q <= (row < HActive) && (col < VActive);
      hs_q     <= (row >= HSyncStart) && (row < HSyncEnd);
      vs_q     <= (col >= VSyncStart) && (col < VSyncEnd);
      re_d     <= re;
      if (re_d) tile_q <= rdata;

      if (row == 10'd0) begin
        xoff_q <= '0;
      end else if (row < HActive) begin
        xoff_q <= (xoff_q == TileMax) ? 5'd0 : xoff_q + 5'd1;
      end

      if (row == 10'd0 && col == 10'd0) begin
        yoff_q <= '0;
      end else if (row == HLast && col < VActive) begin
        yoff_q <= (yoff_q == TileMax) ? 5'd0 : yoff_q + 5'd1;
      end

      hsync <= ~hs_q;
      vsync <= ~vs_q;
      red   <= red_d;
      green <= green_d;
      blue  <= blue_d;

      // Tick is taken straight from row/col so game logic gets the whole blanking interval.
      vblank_q  <= vblank_start;
      game_tick <= 1'b0;
      if (vblank_start && !vblank_q) begin
        if (frame_q == TickMax) begin
          frame_q   <= '0;
          game_tick <= 1'b1;
        end else begin
          frame_q <= frame_q + 6'd1;
        end
      end
    end
  end

endmodule
